// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding and
// the chunk-counter width helper.
package serial_add_sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A one-chunk operation still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_add_sub_chunk_adder.sv
// CHUNK-wide ripple adder built from full-adder cells; also exposes the carry
// into the top bit so the caller can form signed overflow.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_top
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar k = 0; k < CHUNK; k++) begin : g_fa
      assign sum[k]   = x[k] ^ y[k] ^ c[k];
      assign c[k+1]   = (x[k] & y[k]) | (c[k] & (x[k] ^ y[k]));
   end

   assign cout  = c[CHUNK];
   assign c_top = c[CHUNK-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial WIDTH-bit adder/subtractor: CHUNK bits per clock through a
// registered carry, with valid/ready in and out plus carry/overflow/zero flags.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int N_CHUNKS = WIDTH / CHUNK;
   localparam int CW       = cnt_width(N_CHUNKS);

   state_e                   state_q;
   logic [WIDTH-1:0]         a_q, b_q, res_q;
   logic                     carry_q;
   logic [CW-1:0]            cnt_q;
   logic                     in_ready_q, out_valid_q;
   logic                     cout_q, ovf_q, zero_q;

   logic [CHUNK-1:0]         sum_w;
   logic                     add_cout_w, add_ctop_w;
   logic [WIDTH+CHUNK-1:0]   res_cat_w;
   logic [WIDTH-1:0]         res_d;
   logic                     last_w;

   chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .x     (a_q[CHUNK-1:0]),
      .y     (b_q[CHUNK-1:0]),
      .cin   (carry_q),
      .sum   (sum_w),
      .cout  (add_cout_w),
      .c_top (add_ctop_w)
   );

   // New chunk enters at the MSB end; the concatenation keeps CHUNK == WIDTH legal.
   assign res_cat_w = {sum_w, res_q} >> CHUNK;
   assign res_d     = res_cat_w[WIDTH-1:0];
   assign last_w    = (cnt_q == CW'(N_CHUNKS - 1));

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b ^ {WIDTH{sub}};
                  carry_q    <= sub;
                  cnt_q      <= '0;
                  res_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_q     <= a_q >> CHUNK;
               b_q     <= b_q >> CHUNK;
               res_q   <= res_d;
               carry_q <= add_cout_w;
               cnt_q   <= cnt_q + CW'(1);
               if (last_w) begin
                  cout_q      <= add_cout_w;
                  ovf_q       <= add_cout_w ^ add_ctop_w;
                  zero_q      <= (res_d == '0);
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign res       = res_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub across three WIDTH/CHUNK configurations,
// checked against an arithmetic reference model.
module tb_serial_add_sub;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          acc;
   } exp_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed readings of the operands.
   function automatic exp_t model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                  input logic s);
      exp_t   e;
      longint full = longint'(1) << w;
      longint half = longint'(1) << (w - 1);
      longint ua   = longint'(aa) & (full - 1);
      longint ub   = longint'(bb) & (full - 1);
      longint sa   = (ua >= half) ? ua - full : ua;
      longint sb   = (ub >= half) ? ub - full : ub;
      longint r    = s ? ua - ub : ua + ub;
      longint sr   = s ? sa - sb : sa + sb;
      e.res  = 32'(r & (full - 1));
      e.cout = s ? (ua >= ub) : (r >= full);
      e.ovf  = (sr >= half) || (sr < -half);
      e.zero = ((r & (full - 1)) == 0);
      e.acc  = 0;
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g
      localparam int W = (gi == 0) ? 8 : 32;
      localparam int C = (gi == 2) ? 1 : 4;
      localparam int N = W / C;

      logic         in_valid  = 1'b0;
      logic         sub       = 1'b0;
      logic         out_ready = 1'b1;
      logic [W-1:0] a = '0;
      logic [W-1:0] b = '0;
      logic         in_ready, out_valid, cout, ovf, zero;
      logic [W-1:0] res;
      bit           bp_hold = 1'b0;
      bit           rand_bp = 1'b0;
      bit           seen    = 1'b0;
      exp_t         q[$];

      serial_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .a         (a),
         .b         (b),
         .sub       (sub),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .res       (res),
         .cout      (cout),
         .ovf       (ovf),
         .zero      (zero)
      );

      task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic ss);
         exp_t e;
         int   waited = 0;
         @(negedge clk);
         a        = aa[W-1:0];
         b        = bb[W-1:0];
         sub      = ss;
         in_valid = 1'b1;
         while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
         end
         if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL g%0d accept: in_ready stuck at 0, required 1 within 200 cycles", gi);
            in_valid = 1'b0;
            return;
         end
         e     = model(W, aa, bb, ss);
         e.acc = cyc + 1;
         q.push_back(e);
         @(negedge clk);
         in_valid = 1'b0;
         a        = W'($urandom);
         b        = W'($urandom);
         sub      = 1'($urandom_range(0, 1));
      endtask

      task automatic drain();
         int n = 0;
         while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
         end
         if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL g%0d drain: %0d results pending, required 0", gi, q.size());
         end
      endtask

      // Monitor: out_ready is chosen first so the pop matches the coming edge's handshake.
      always @(negedge clk) begin
         if (rst) begin
            q.delete();
            seen = 1'b0;
         end else begin
            out_ready = bp_hold ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
            if (out_valid) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL g%0d spurious out_valid: res=0x%0h, required no output", gi, res);
               end else begin
                  check($sformatf("g%0d res", gi),      32'(res),  q[0].res);
                  check($sformatf("g%0d cout", gi),     32'(cout), 32'(q[0].cout));
                  check($sformatf("g%0d ovf", gi),      32'(ovf),  32'(q[0].ovf));
                  check($sformatf("g%0d zero", gi),     32'(zero), 32'(q[0].zero));
                  check($sformatf("g%0d in_ready", gi), 32'(in_ready), 32'd0);
                  if (!seen) begin
                     check($sformatf("g%0d latency", gi), 32'(cyc - q[0].acc), 32'(N));
                     seen = 1'b1;
                  end
                  if (out_ready) begin
                     void'(q.pop_front());
                     seen = 1'b0;
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset in_ready",  32'(g[0].in_ready),  32'd1);
      check("reset out_valid", 32'(g[0].out_valid), 32'd0);
      check("reset res",       32'(g[0].res),       32'd0);
      check("reset flags",     {29'd0, g[0].cout, g[0].ovf, g[0].zero}, 32'd0);
      rst = 1'b0;

      g[0].issue(32'h7F, 32'h01, 1'b0);
      g[0].issue(32'h05, 32'h07, 1'b1);
      g[0].issue(32'h80, 32'h01, 1'b1);
      g[0].issue(32'h33, 32'h33, 1'b1);
      g[0].drain();
      g[1].issue(32'hFFFF_FFFF, 32'h1, 1'b0);
      g[1].drain();
      g[2].issue(32'hFFFF_FFFF, 32'h1, 1'b0);
      g[2].drain();

      // Backpressure: hold DONE, wiggle in_valid with fresh operands.
      g[0].bp_hold = 1'b1;
      g[0].issue(32'h12, 32'h34, 1'b0);
      n = 0;
      while (!g[0].out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp out_valid reached", 32'(g[0].out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         g[0].in_valid = ~g[0].in_valid;
         g[0].a        = 8'($urandom);
         g[0].b        = 8'($urandom);
         check("bp in_ready", 32'(g[0].in_ready), 32'd0);
         check("bp out_valid held", 32'(g[0].out_valid), 32'd1);
      end
      @(posedge clk);
      g[0].in_valid = 1'b0;
      g[0].bp_hold  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("bp release in_ready",  32'(g[0].in_ready),  32'd1);
      check("bp release out_valid", 32'(g[0].out_valid), 32'd0);
      g[0].drain();

      // Reset in the middle of RUN.
      g[0].issue(32'hAA, 32'h55, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid-run rst in_ready",  32'(g[0].in_ready),  32'd1);
      check("mid-run rst out_valid", 32'(g[0].out_valid), 32'd0);
      check("mid-run rst res",       32'(g[0].res),       32'd0);
      check("mid-run rst flags",     {29'd0, g[0].cout, g[0].ovf, g[0].zero}, 32'd0);
      rst = 1'b0;
      g[0].issue(32'h10, 32'h20, 1'b0);
      g[0].drain();

      g[0].rand_bp = 1'b1;
      g[1].rand_bp = 1'b1;
      g[2].rand_bp = 1'b1;
      for (int i = 0; i < 40; i++) g[0].issue(pick(), pick(), 1'($urandom_range(0, 1)));
      g[0].drain();
      for (int i = 0; i < 40; i++) g[1].issue(pick(), pick(), 1'($urandom_range(0, 1)));
      g[1].drain();
      for (int i = 0; i < 25; i++) g[2].issue(pick(), pick(), 1'($urandom_range(0, 1)));
      g[2].drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
